// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the fetch/MEM memory-port arbiter.
package mips_arb_pkg;

    localparam int MEM_ARB_DATA_W = 32;
    localparam int MEM_ARB_BE_W   = 4;

    // Arbiter sequencer states: one access outstanding at a time
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_M = 2'd2
    } arb_state_t;

    // Grant selection made in IDLE
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_M    = 2'd2
    } arb_gnt_t;

    // MEM wins ties unless it has used up its run while fetch waited
    function automatic arb_gnt_t arb_pick(input logic f_req,
                                          input logic m_req,
                                          input logic run_full);
        if (m_req && (!f_req || !run_full)) return GNT_M;
        if (f_req) return GNT_F;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/arb_stall_counter.sv
// 32-bit saturating event counter with enable, used for stall statistics.
module arb_stall_counter
    import mips_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic [MEM_ARB_DATA_W-1:0] count
);

    // Count enabled cycles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch (F) and MEM stages.
// MEM has priority; a run counter hands the port to a waiting fetch after
// MAX_MEM_RUN consecutive MEM grants. Each access holds the port for
// MEM_LAT+2 cycles: grant, RAM strobe, wait, completion.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int MEM_LAT     = 2,
    parameter int MAX_MEM_RUN = 4
) (
    input  logic                      SYS_clk,
    input  logic                      SYS_reset_n,

    input  logic                      F_req,
    input  logic [MEM_ARB_DATA_W-1:0] F_addr,
    output logic [MEM_ARB_DATA_W-1:0] F_rdata,
    output logic                      F_valid,
    output logic                      F_stall,

    input  logic                      MEM_req,
    input  logic                      MEM_we,
    input  logic [MEM_ARB_DATA_W-1:0] MEM_addr,
    input  logic [MEM_ARB_DATA_W-1:0] MEM_wdata,
    input  logic [MEM_ARB_BE_W-1:0]   MEM_be,
    output logic [MEM_ARB_DATA_W-1:0] MEM_rdata,
    output logic                      MEM_valid,
    output logic                      MEM_stall,

    output logic                      RAM_en,
    output logic                      RAM_we,
    output logic [MEM_ARB_DATA_W-1:0] RAM_addr,
    output logic [MEM_ARB_DATA_W-1:0] RAM_wdata,
    output logic [MEM_ARB_BE_W-1:0]   RAM_be,
    input  logic [MEM_ARB_DATA_W-1:0] RAM_rdata,

    output logic [MEM_ARB_DATA_W-1:0] ARB_f_stall_cnt,
    output logic [MEM_ARB_DATA_W-1:0] ARB_mem_stall_cnt
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_MEM_RUN);

    arb_state_t state;
    arb_state_t state_nxt;
    arb_gnt_t   gnt;
    logic [2:0] lat_cnt;
    logic [3:0] run_cnt;
    logic       acc_we;
    logic       done;

    assign done = (lat_cnt == 3'd0);

    // State register
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_nxt = state;
        gnt       = GNT_NONE;
        case (state)
            IDLE: begin
                gnt = arb_pick(F_req, MEM_req, run_cnt == RUN_MAX);
                if (gnt == GNT_F) state_nxt = BUSY_F;
                else if (gnt == GNT_M) state_nxt = BUSY_M;
            end
            BUSY_F, BUSY_M: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion pulses; read data is passed straight through on the completion cycle
    always_comb begin
        F_valid   = (state == BUSY_F) && done;
        MEM_valid = (state == BUSY_M) && done;
        F_rdata   = F_valid ? RAM_rdata : '0;
        MEM_rdata = (MEM_valid && !acc_we) ? RAM_rdata : '0;
    end

    assign F_stall   = F_req & ~F_valid;
    assign MEM_stall = MEM_req & ~MEM_valid;

    // Capture the granted request and drive the one-cycle RAM strobe
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            RAM_en    <= 1'b0;
            RAM_we    <= 1'b0;
            RAM_addr  <= '0;
            RAM_wdata <= '0;
            RAM_be    <= '0;
            acc_we    <= 1'b0;
        end else begin
            RAM_en <= (gnt != GNT_NONE);
            RAM_we <= (gnt == GNT_M) && MEM_we;
            if (gnt == GNT_M) begin
                RAM_addr  <= MEM_addr;
                RAM_wdata <= MEM_wdata;
                RAM_be    <= MEM_be;
                acc_we    <= MEM_we;
            end else if (gnt == GNT_F) begin
                RAM_addr  <= F_addr;
                acc_we    <= 1'b0;
            end
        end
    end

    // Latency countdown and MEM run length tracking
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            lat_cnt <= '0;
            run_cnt <= '0;
        end else begin
            if (gnt != GNT_NONE) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state != IDLE) && !done) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (gnt == GNT_F) begin
                run_cnt <= '0;
            end else if (gnt == GNT_M) begin
                run_cnt <= F_req ? (run_cnt + 1'b1) : 4'd0;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    arb_stall_counter u_f_stall_cnt (
        .clk   (SYS_clk),
        .rst_n (SYS_reset_n),
        .en    (F_stall),
        .count (ARB_f_stall_cnt)
    );

    arb_stall_counter u_mem_stall_cnt (
        .clk   (SYS_clk),
        .rst_n (SYS_reset_n),
        .en    (MEM_stall),
        .count (ARB_mem_stall_cnt)
    );
`else
    assign ARB_f_stall_cnt   = '0;
    assign ARB_mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected
// RAM strobes and completions; a monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
`ifdef MEM_ARB_PERF_CNT_EN
    localparam int EXP_F_CNT = 7;
    localparam int EXP_M_CNT = 3;
`else
    localparam int EXP_F_CNT = 0;
    localparam int EXP_M_CNT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        F_req = 1'b0;
    logic [31:0] F_addr = '0;
    logic [31:0] F_rdata;
    logic        F_valid, F_stall;
    logic        MEM_req = 1'b0;
    logic        MEM_we = 1'b0;
    logic [31:0] MEM_addr = '0;
    logic [31:0] MEM_wdata = '0;
    logic [3:0]  MEM_be = '0;
    logic [31:0] MEM_rdata;
    logic        MEM_valid, MEM_stall;
    logic        RAM_en, RAM_we;
    logic [31:0] RAM_addr, RAM_wdata, RAM_rdata;
    logic [3:0]  RAM_be;
    logic [31:0] ARB_f_stall_cnt, ARB_mem_stall_cnt;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;
    int rd_due = -1;
    logic [31:0] rd_data = '0;

    typedef struct {int cyc; logic [31:0] data;} rsp_t;
    typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} ram_t;
    rsp_t f_exp[$];
    rsp_t m_exp[$];
    ram_t r_exp[$];
    rsp_t fe, me;
    ram_t re;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_MEM_RUN(4)) dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n),
        .F_req(F_req), .F_addr(F_addr), .F_rdata(F_rdata), .F_valid(F_valid), .F_stall(F_stall),
        .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
        .MEM_be(MEM_be), .MEM_rdata(MEM_rdata), .MEM_valid(MEM_valid), .MEM_stall(MEM_stall),
        .RAM_en(RAM_en), .RAM_we(RAM_we), .RAM_addr(RAM_addr), .RAM_wdata(RAM_wdata),
        .RAM_be(RAM_be), .RAM_rdata(RAM_rdata),
        .ARB_f_stall_cnt(ARB_f_stall_cnt), .ARB_mem_stall_cnt(ARB_mem_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h8C08_0004;
        return a ^ 32'hC3C3_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // RAM model: read data is present only on the cycle MEM_LAT after the strobe
    always @(posedge clk) begin
        if (RAM_en && !RAM_we) begin
            rd_due  <= cyc + MEM_LAT;
            rd_data <= lookup(RAM_addr);
        end
        cyc <= cyc + 1;
    end
    assign RAM_rdata = (cyc == rd_due) ? rd_data : 32'hBAD0_BAD0;

    // Monitor: compare every strobe and completion with the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (F_valid) begin
                if (f_exp.size() == 0) check("f_valid_unexpected", 32'(f_exp.size()), 32'd1);
                else begin
                    fe = f_exp.pop_front();
                    check("f_valid_cycle", 32'(cyc), 32'(fe.cyc));
                    check("f_rdata", F_rdata, fe.data);
                end
            end
            if (MEM_valid) begin
                if (m_exp.size() == 0) check("mem_valid_unexpected", 32'(m_exp.size()), 32'd1);
                else begin
                    me = m_exp.pop_front();
                    check("mem_valid_cycle", 32'(cyc), 32'(me.cyc));
                    check("mem_rdata", MEM_rdata, me.data);
                end
            end
            if (RAM_en) begin
                if (r_exp.size() == 0) check("ram_en_unexpected", 32'(r_exp.size()), 32'd1);
                else begin
                    re = r_exp.pop_front();
                    check("ram_en_cycle", 32'(cyc), 32'(re.cyc));
                    check("ram_addr", RAM_addr, re.addr);
                    check("ram_we", 32'(RAM_we), 32'(re.we));
                    if (re.we) begin
                        check("ram_wdata", RAM_wdata, re.wdata);
                        check("ram_be", 32'(RAM_be), 32'(re.be));
                    end
                end
            end
        end
    end

    task automatic push_r(input int c, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        ram_t r;
        r.cyc = c; r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        r_exp.push_back(r);
    endtask

    task automatic push_f(input int c, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.data = d;
        f_exp.push_back(r);
    endtask

    task automatic push_m(input int c, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.data = d;
        m_exp.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic f_access(input logic [31:0] a);
        bit got = 0;
        F_addr = a;
        F_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (F_valid) begin got = 1; break; end
        end
        check("f_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        F_req = 1'b0;
    endtask

    task automatic m_access(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        bit got = 0;
        MEM_we = we; MEM_addr = a; MEM_wdata = wd; MEM_be = be;
        MEM_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MEM_valid) begin got = 1; break; end
        end
        check("mem_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        MEM_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen;

        // Reset state
        idle(3);
        check("rst_f_valid", 32'(F_valid), 32'd0);
        check("rst_mem_valid", 32'(MEM_valid), 32'd0);
        check("rst_f_rdata", F_rdata, 32'd0);
        check("rst_mem_rdata", MEM_rdata, 32'd0);
        check("rst_ram_en", 32'(RAM_en), 32'd0);
        check("rst_ram_addr", RAM_addr, 32'd0);
        check("rst_ram_wdata", RAM_wdata, 32'd0);
        check("rst_ram_be", 32'(RAM_be), 32'd0);
        check("rst_f_cnt", ARB_f_stall_cnt, 32'd0);
        check("rst_m_cnt", ARB_mem_stall_cnt, 32'd0);
        F_req = 1'b1; #1;
        check("rst_f_stall_follows", 32'(F_stall), 32'd1);
        F_req = 1'b0; #1;
        check("rst_f_stall_low", 32'(F_stall), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Simultaneous requests: MEM first, then fetch
        base = cyc;
        push_r(base + 1, 1'b0, 32'h2000, 32'h0, 4'h0);
        push_r(base + 5, 1'b0, 32'h0300, 32'h0, 4'h0);
        push_m(base + 3, lookup(32'h2000));
        push_f(base + 7, lookup(32'h0300));
        fork
            m_access(1'b0, 32'h2000, 32'h0, 4'hF);
            f_access(32'h0300);
        join
        @(negedge clk);
        check("f_stall_cnt", ARB_f_stall_cnt, 32'(EXP_F_CNT));
        check("mem_stall_cnt", ARB_mem_stall_cnt, 32'(EXP_M_CNT));
        idle(2);

        // Lone fetch with stall profile
        base = cyc;
        push_r(base + 1, 1'b0, 32'h0100, 32'h0, 4'h0);
        push_f(base + 3, 32'h8C08_0004);
        fork
            f_access(32'h0100);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("lone_f_stall", 32'(F_stall), (k < 3) ? 32'd1 : 32'd0);
            end
        join
        idle(2);

        // Store: write strobe, zero load data
        base = cyc;
        push_r(base + 1, 1'b1, 32'h0600, 32'hDEAD_BEEF, 4'b0011);
        push_m(base + 3, 32'h0);
        m_access(1'b1, 32'h0600, 32'hDEAD_BEEF, 4'b0011);
        idle(2);

        // Starvation guard: four MEM grants, then fetch, then MEM again
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            push_r(base + 1 + 4 * i, 1'b0, 32'h4000 + 32'(4 * i), 32'h0, 4'h0);
            push_m(base + 3 + 4 * i, lookup(32'h4000 + 32'(4 * i)));
        end
        push_r(base + 17, 1'b0, 32'h0500, 32'h0, 4'h0);
        push_f(base + 19, lookup(32'h0500));
        push_r(base + 21, 1'b0, 32'h4010, 32'h0, 4'h0);
        push_m(base + 23, lookup(32'h4010));
        fork
            for (int i = 0; i < 5; i++) m_access(1'b0, 32'h4000 + 32'(4 * i), 32'h0, 4'hF);
            f_access(32'h0500);
        join
        idle(2);

        // Reset in the middle of a MEM access
        base = cyc;
        push_r(base + 1, 1'b0, 32'h0700, 32'h0, 4'h0);
        MEM_we = 1'b0; MEM_addr = 32'h0700; MEM_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check("midrst_ram_en", 32'(RAM_en), 32'd0);
        check("midrst_mem_valid", 32'(MEM_valid), 32'd0);
        check("midrst_mem_stall", 32'(MEM_stall), 32'd1);
        MEM_req = 1'b0; #1;
        check("midrst_mem_stall_low", 32'(MEM_stall), 32'd0);
        idle(2);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (MEM_valid || F_valid || RAM_en) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        idle(1);
        base = cyc;
        push_r(base + 1, 1'b0, 32'h0704, 32'h0, 4'h0);
        push_m(base + 3, lookup(32'h0704));
        m_access(1'b0, 32'h0704, 32'h0, 4'hF);
        idle(5);

        check("f_queue_empty", 32'(f_exp.size()), 32'd0);
        check("m_queue_empty", 32'(m_exp.size()), 32'd0);
        check("r_queue_empty", 32'(r_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
